// File: rtl/adder_if.sv
// Operand/result bundle for the registered adder.
// The master drives operands; the slave (the adder) returns registered results.
interface adder_if #(
  parameter int unsigned WIDTH = 1
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             cin_sel;
  logic             in_valid;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             out_valid;

  modport master (
    output a, b, cin, cin_sel, in_valid,
    input  s, cout, ovf, zero, out_valid
  );

  modport slave (
    input  a, b, cin, cin_sel, in_valid,
    output s, cout, ovf, zero, out_valid
  );
endinterface

// File: rtl/adder.sv
// Registered WIDTH-bit adder with selectable carry-in and a chained-carry register
// for multi-word addition; one-cycle latency, one result per cycle.
module adder #(
  parameter int unsigned WIDTH = 1
) (
  input  logic    clk,
  input  logic    rst,
  adder_if.slave  bus
);

  localparam int unsigned MSB = WIDTH - 1;
  localparam int unsigned SW  = WIDTH + 1;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             zero;
  } result_t;

  localparam result_t RESULT_RST = '{s: '0, cout: 1'b0, ovf: 1'b0, zero: 1'b1};

  result_t          res_q;
  result_t          res_n;
  logic             valid_q;
  logic             chain_q;
  logic             c_eff;
  logic [WIDTH:0]   sum_full;

  // Carry source select and full-width sum, carry kept in the top bit
  always_comb begin
    c_eff    = bus.cin_sel ? chain_q : bus.cin;
    sum_full = {1'b0, bus.a} + {1'b0, bus.b} + SW'(c_eff);
  end

  // Next result: signed overflow when like-signed operands yield a differently signed sum
  always_comb begin
    res_n      = RESULT_RST;
    res_n.s    = sum_full[MSB:0];
    res_n.cout = sum_full[WIDTH];
    res_n.ovf  = (bus.a[MSB] == bus.b[MSB]) && (sum_full[MSB] != bus.a[MSB]);
    res_n.zero = (sum_full[MSB:0] == '0);
  end

  // Results and chain carry only advance on valid operands; out_valid is a one-cycle strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q   <= RESULT_RST;
      valid_q <= 1'b0;
      chain_q <= 1'b0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        res_q   <= res_n;
        chain_q <= res_n.cout;
      end
    end
  end

  assign bus.s         = res_q.s;
  assign bus.cout      = res_q.cout;
  assign bus.ovf       = res_q.ovf;
  assign bus.zero      = res_q.zero;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_adder.sv
// Scoreboard bench for adder at WIDTH=1 and WIDTH=8, driven in lockstep from one
// directed sequence; each result is checked one cycle after its operands.
module tb_adder;

  typedef struct packed {
    logic [7:0] s;
    logic       cout;
    logic       ovf;
    logic       zero;
  } exp_t;

  localparam exp_t EXP_RST = '{s: 8'h00, cout: 1'b0, ovf: 1'b0, zero: 1'b1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  exp_t q1[$];
  exp_t q8[$];
  exp_t last1 = EXP_RST;
  exp_t last8 = EXP_RST;
  logic chain1 = 1'b0;
  logic chain8 = 1'b0;

  always #5 clk = ~clk;

  adder_if #(.WIDTH(1)) bus1();
  adder_if #(.WIDTH(8)) bus8();

  adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_w1_s"},         8'(bus1.s),         8'h00);
    chk({tag, "_w1_cout"},      8'(bus1.cout),      8'h00);
    chk({tag, "_w1_zero"},      8'(bus1.zero),      8'h01);
    chk({tag, "_w1_out_valid"}, 8'(bus1.out_valid), 8'h00);
    chk({tag, "_w8_s"},         bus8.s,             8'h00);
    chk({tag, "_w8_cout"},      8'(bus8.cout),      8'h00);
    chk({tag, "_w8_ovf"},       8'(bus8.ovf),       8'h00);
    chk({tag, "_w8_zero"},      8'(bus8.zero),      8'h01);
    chk({tag, "_w8_out_valid"}, 8'(bus8.out_valid), 8'h00);
  endtask

  task automatic idle_inputs();
    bus1.in_valid = 1'b0;
    bus1.a        = 1'($urandom);
    bus1.b        = 1'($urandom);
    bus1.cin      = 1'($urandom);
    bus1.cin_sel  = 1'($urandom);
    bus8.in_valid = 1'b0;
    bus8.a        = 8'($urandom);
    bus8.b        = 8'($urandom);
    bus8.cin      = 1'($urandom);
    bus8.cin_sel  = 1'($urandom);
  endtask

  // One clock: compare both DUTs against the scoreboard; idle cycles must hold the last result
  task automatic tick();
    bit p1;
    bit p8;
    p1 = (q1.size() > 0);
    p8 = (q8.size() > 0);
    @(posedge clk);
    #1;
    if (p1) last1 = q1.pop_front();
    if (p8) last8 = q8.pop_front();
    chk("w1_out_valid", 8'(bus1.out_valid), 8'(p1));
    chk("w1_s",         8'(bus1.s),         last1.s);
    chk("w1_cout",      8'(bus1.cout),      8'(last1.cout));
    chk("w1_ovf",       8'(bus1.ovf),       8'(last1.ovf));
    chk("w1_zero",      8'(bus1.zero),      8'(last1.zero));
    chk("w8_out_valid", 8'(bus8.out_valid), 8'(p8));
    chk("w8_s",         bus8.s,             last8.s);
    chk("w8_cout",      8'(bus8.cout),      8'(last8.cout));
    chk("w8_ovf",       8'(bus8.ovf),       8'(last8.ovf));
    chk("w8_zero",      8'(bus8.zero),      8'(last8.zero));
    idle_inputs();
  endtask

  // 1-bit full adder truth model
  task automatic issue1(input logic a, input logic b, input logic cin, input logic sel);
    logic c;
    exp_t e;
    c      = sel ? chain1 : cin;
    e      = EXP_RST;
    e.s    = 8'(a ^ b ^ c);
    e.cout = (a & b) | (a & c) | (b & c);
    e.ovf  = (a == b) && ((a ^ b ^ c) != a);
    e.zero = ((a ^ b ^ c) == 1'b0);
    q1.push_back(e);
    chain1 = e.cout;
    bus1.a = a; bus1.b = b; bus1.cin = cin; bus1.cin_sel = sel; bus1.in_valid = 1'b1;
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sel);
    logic [8:0] sum;
    exp_t e;
    sum    = 9'(a) + 9'(b) + 9'(sel ? chain8 : cin);
    e      = EXP_RST;
    e.s    = sum[7:0];
    e.cout = sum[8];
    e.ovf  = (a[7] == b[7]) && (sum[7] != a[7]);
    e.zero = (sum[7:0] == 8'h00);
    q8.push_back(e);
    chain8 = e.cout;
    bus8.a = a; bus8.b = b; bus8.cin = cin; bus8.cin_sel = sel; bus8.in_valid = 1'b1;
  endtask

  task automatic issue8_exp(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sel,
                            input logic [7:0] es, input logic ec, input logic eo, input logic ez);
    q8.push_back('{s: es, cout: ec, ovf: eo, zero: ez});
    chain8 = ec;
    bus8.a = a; bus8.b = b; bus8.cin = cin; bus8.cin_sel = sel; bus8.in_valid = 1'b1;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_reset("por");
    rst = 1'b0;

    // WIDTH=1 exhaustive over a, b, cin
    for (int i = 0; i < 8; i++) begin
      issue1(1'(i >> 2), 1'(i >> 1), 1'(i), 1'b0);
      tick();
    end

    // WIDTH=8 directed corner cases
    issue8_exp(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    tick();
    issue8_exp(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    tick();
    issue8_exp(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
    tick();

    // Chained two-word add; cin held 0 so only the chain register can supply the carry
    issue8_exp(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    issue1(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    issue8_exp(8'h00, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    issue1(1'b0, 1'b0, 1'b0, 1'b1);
    tick();

    // Single pulse then idle: out_valid for one cycle, outputs held
    issue8(8'h3C, 8'h05, 1'b1, 1'b0);
    issue1(1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    repeat (3) tick();

    // Back-to-back random stream with mixed carry sources
    for (int i = 0; i < 24; i++) begin
      issue8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      issue1(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      tick();
    end

    // Reset between edges with a result in flight
    issue8(8'h12, 8'h34, 1'b0, 1'b0);
    issue1(1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    issue8(8'hF0, 8'h20, 1'b0, 1'b0);
    issue1(1'b1, 1'b1, 1'b0, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    chk_reset("async_rst");
    q1.delete();
    q8.delete();
    last1  = EXP_RST;
    last8  = EXP_RST;
    chain1 = 1'b0;
    chain8 = 1'b0;
    @(posedge clk);
    #1;
    chk_reset("rst_held");

    // Release just after an edge; first op after release uses the cleared chain register
    rst = 1'b0;
    issue8(8'h00, 8'h00, 1'b1, 1'b1);
    issue1(1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    issue8(8'h80, 8'h80, 1'b0, 1'b0);
    issue1(1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    issue8(8'h01, 8'h02, 1'b0, 1'b1);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
